reg_writeback_queue: RTL and testbench
======================================

// Module: reg_writeback_queue
// PURPOSE
//  Initiator side of the register-file write port. Buffers register writes from late
//  producers (multi-cycle mul/div, load unit) and drains them one at a time into
//  RegWrite/WriteReg/WriteData. It drains only when the pipeline grants the shared
//  write port. Optional forwarding lets decode read values that are still queued.
// PARAMETERS
//  DEPTH       4    queue entries; power of 2, range 2..16
//  PTR_W       2    log2(DEPTH); must match DEPTH
// PORTS
//  CLK         in   1   clock; all state updates on rising edge
//  Reset       in   1   synchronous, active-high reset
//  InValid     in   1   producer offers a write this cycle
//  InReady     out  1   queue can accept (count < DEPTH)
//  InReg       in   5   destination register
//  InData      in   32  write data
//  WbGrant     in   1   pipeline grants the register-file write port this cycle
//  RegWrite    out  1   to register file: write enable
//  WriteReg    out  5   to register file: destination (head entry)
//  WriteData   out  32  to register file: data (head entry)
//  Count       out  PTR_W+1  occupied entries
//  LookupReg1  in   5   decode read address 1 (forwarding)
//  LookupReg2  in   5   decode read address 2 (forwarding)
//  Hit1/Hit2   out  1   a queued entry matches LookupRegN
//  HitData1/2  out  32  data of the youngest matching entry
// BEHAVIOUR
//  - Circular buffer: head/tail pointers PTR_W bits wide, plus a count PTR_W+1 bits wide.
//    Pointers wrap modulo DEPTH.
//  - Reset=1 at a rising edge: head=tail=count=0. All queued entries are discarded, even
//    mid-drain. Outputs after reset: InReady=1, RegWrite=0, WriteReg=0, WriteData=0,
//    Count=0, Hit1=Hit2=0, HitData1/2=0.
//  - Accept: push = InValid & InReady & (InReg != 0). InValid with InReg==0 is consumed
//    and dropped: no entry is stored and it is counted as accepted. $zero is never written.
//  - Present: RegWrite = (count != 0) & WbGrant. WriteReg/WriteData = head entry when
//    count != 0, else 0. These are combinational from registered state.
//  - Pop: pop = (count != 0) & WbGrant at the rising edge. The register file captures the
//    write on the following falling edge within the same cycle.
//  - Latency: an entry pushed in cycle N is presented in cycle N+1 at the earliest.
//    Writes retire in strict FIFO order.
//  - Simultaneous push and pop: count is unchanged and both pointers advance.
//  - Full: InReady=0 whenever count==DEPTH, even if a pop occurs that cycle. There is no
//    same-cycle pass-through.
//  - Empty: RegWrite=0 regardless of WbGrant. No pointer movement.
//  - Same InReg queued twice: both entries retire in order, so the last-pushed value ends
//    up in the register file.
// CONFIGURATION
//  WBQ_FORWARD_EN defined:
//    - HitN=1 when any valid entry has reg == LookupRegN and LookupRegN != 0.
//    - HitDataN = data of the youngest (closest to tail) match. Search is combinational.
//    - An entry popped this cycle still counts as a hit this cycle.
//    - Entries being pushed this cycle are not searched.
//  WBQ_FORWARD_EN undefined:
//    - Hit1/Hit2/HitData1/HitData2 tied to 0. No comparators are built.
// TESTING
//  1. Reset; push (r5, 0x1234) with WbGrant=0 -> Count=1, RegWrite=0. Then WbGrant=1 ->
//     RegWrite=1, WriteReg=5, WriteData=0x1234. Next cycle Count=0.
//  2. Push 4 entries with WbGrant=0 (DEPTH=4) -> InReady=0, Count=4. Assert WbGrant and
//     keep InValid=1 -> InReady stays 0 in the pop cycle and returns to 1 the next cycle.
//  3. Push (r0, 0xFFFF) -> accepted, Count stays 0, RegWrite never asserts.
//  4. Push (r7,0xA), (r7,0xB) with WbGrant=0; LookupReg1=7 -> Hit1=1, HitData1=0xB. Drain
//     -> writes 0xA then 0xB. After drain, Hit1=0. Without the macro, Hit1 stays 0
//     throughout.
//  5. Three entries queued; assert Reset for one cycle with WbGrant=1 -> Count=0,
//     RegWrite=0 next cycle. No further writes issue.
//  6. Steady state with InValid=1 and WbGrant=1 every cycle for 20 cycles -> Count holds
//     at 1. Writes retire in push order with one-cycle latency.

Source files
------------

// File: rtl/reg_writeback_queue_if.sv
// Bundle of the write-queue producer, register-file write port and forwarding lookup signals.
// master: the queue itself; slave: producers, pipeline grant logic and decode.
interface reg_writeback_queue_if #(
    parameter int unsigned PTR_W = 2
);
    logic             InValid;
    logic             InReady;
    logic [4:0]       InReg;
    logic [31:0]      InData;
    logic             WbGrant;
    logic             RegWrite;
    logic [4:0]       WriteReg;
    logic [31:0]      WriteData;
    logic [PTR_W:0]   Count;
    logic [4:0]       LookupReg1;
    logic [4:0]       LookupReg2;
    logic             Hit1;
    logic             Hit2;
    logic [31:0]      HitData1;
    logic [31:0]      HitData2;

    modport master (
        input  InValid, InReg, InData, WbGrant, LookupReg1, LookupReg2,
        output InReady, RegWrite, WriteReg, WriteData, Count,
               Hit1, Hit2, HitData1, HitData2
    );

    modport slave (
        output InValid, InReg, InData, WbGrant, LookupReg1, LookupReg2,
        input  InReady, RegWrite, WriteReg, WriteData, Count,
               Hit1, Hit2, HitData1, HitData2
    );
endinterface

// File: rtl/reg_writeback_queue.sv
// Circular write-back queue feeding the shared register-file write port in FIFO order.
// Define WBQ_FORWARD_EN to build the decode forwarding search over queued entries.
module reg_writeback_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic                  CLK,
    input  logic                  Reset,
    reg_writeback_queue_if.master bus
);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [4:0]  reg_q  [DEPTH];
    logic [4:0]  reg_d  [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [31:0] data_d [DEPTH];
    ptr_t        head_q, head_d;
    ptr_t        tail_q, tail_d;
    cnt_t        count_q, count_d;
    logic        not_empty;
    logic        in_ready;
    logic        push;
    logic        pop;

    // Next-state for storage, pointers and occupancy; $zero writes are consumed without storing.
    always_comb begin
        not_empty = (count_q != '0);
        in_ready  = (count_q != cnt_t'(DEPTH));
        push      = bus.InValid & in_ready & (bus.InReg != 5'd0);
        pop       = not_empty & bus.WbGrant;
        reg_d     = reg_q;
        data_d    = data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (push) begin
            reg_d[tail_q]  = bus.InReg;
            data_d[tail_q] = bus.InData;
            tail_d         = tail_q + ptr_t'(1);
        end
        if (pop) begin
            head_d = head_q + ptr_t'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
        end
    end

    assign bus.InReady   = in_ready;
    assign bus.RegWrite  = pop;
    assign bus.WriteReg  = not_empty ? reg_q[head_q]  : 5'd0;
    assign bus.WriteData = not_empty ? data_q[head_q] : 32'd0;
    assign bus.Count     = count_q;

`ifdef WBQ_FORWARD_EN
    logic        hit1, hit2;
    logic [31:0] hit_data1, hit_data2;
    ptr_t        idx;

    // Walk oldest to youngest so the last match found is the one closest to the tail.
    always_comb begin
        hit1      = 1'b0;
        hit2      = 1'b0;
        hit_data1 = '0;
        hit_data2 = '0;
        idx       = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + ptr_t'(i);
            if (cnt_t'(i) < count_q) begin
                if ((bus.LookupReg1 != 5'd0) && (reg_q[idx] == bus.LookupReg1)) begin
                    hit1      = 1'b1;
                    hit_data1 = data_q[idx];
                end
                if ((bus.LookupReg2 != 5'd0) && (reg_q[idx] == bus.LookupReg2)) begin
                    hit2      = 1'b1;
                    hit_data2 = data_q[idx];
                end
            end
        end
    end

    assign bus.Hit1     = hit1;
    assign bus.Hit2     = hit2;
    assign bus.HitData1 = hit_data1;
    assign bus.HitData2 = hit_data2;
`else
    logic unused_lookup;

    assign unused_lookup = ^{bus.LookupReg1, bus.LookupReg2};
    assign bus.Hit1      = 1'b0;
    assign bus.Hit2      = 1'b0;
    assign bus.HitData1  = '0;
    assign bus.HitData2  = '0;
`endif
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Scoreboard bench for reg_writeback_queue: expected writes queued at stimulus, checked by a monitor.
module tb_reg_writeback_queue;
`ifdef WBQ_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t expq[$];

    reg_writeback_queue_if #(.PTR_W(2)) bus ();

    reg_writeback_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .CLK  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [4:0] r, input logic [31:0] d);
        exp_t e;
        e.r = r;
        e.d = d;
        if (r != 5'd0) expq.push_back(e);
    endtask

    // Monitor: every write presented to the register file must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && bus.RegWrite === 1'b1) begin
            if (expq.size() == 0) begin
                chk("unexpected_write", 32'(bus.WriteReg), 32'hDEAD);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("write_reg", 32'(bus.WriteReg), 32'(e.r));
                chk("write_data", bus.WriteData, e.d);
            end
        end
    end

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        bus.InValid    = 1'b0;
        bus.InReg      = '0;
        bus.InData     = '0;
        bus.WbGrant    = 1'b0;
        bus.LookupReg1 = '0;
        bus.LookupReg2 = '0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_count", 32'(bus.Count), 32'd0);
        chk("rst_in_ready", 32'(bus.InReady), 32'd1);
        chk("rst_regwrite", 32'(bus.RegWrite), 32'd0);
        chk("rst_write_reg", 32'(bus.WriteReg), 32'd0);
        chk("rst_write_data", bus.WriteData, 32'd0);
        chk("rst_hit1", 32'(bus.Hit1), 32'd0);
        chk("rst_hitdata2", bus.HitData2, 32'd0);

        // Single push, held, then granted.
        bus.InValid = 1'b1; bus.InReg = 5'd5; bus.InData = 32'h1234;
        exp_push(5'd5, 32'h1234);
        cyc();
        bus.InValid = 1'b0;
        #1;
        chk("t1_count", 32'(bus.Count), 32'd1);
        chk("t1_no_write", 32'(bus.RegWrite), 32'd0);
        chk("t1_head_reg", 32'(bus.WriteReg), 32'd5);
        bus.WbGrant = 1'b1;
        #1;
        chk("t1_regwrite", 32'(bus.RegWrite), 32'd1);
        cyc();
        bus.WbGrant = 1'b0;
        #1;
        chk("t1_drained", 32'(bus.Count), 32'd0);

        // Fill to DEPTH, then pop while a producer keeps offering.
        for (int i = 0; i < 4; i++) begin
            bus.InValid = 1'b1; bus.InReg = 5'(i + 1); bus.InData = 32'h100 + 32'(i);
            exp_push(5'(i + 1), 32'h100 + 32'(i));
            cyc();
        end
        bus.InValid = 1'b0;
        #1;
        chk("t2_full_count", 32'(bus.Count), 32'd4);
        chk("t2_full_ready", 32'(bus.InReady), 32'd0);
        bus.WbGrant = 1'b1; bus.InValid = 1'b1; bus.InReg = 5'd9; bus.InData = 32'h999;
        #1;
        chk("t2_ready_in_pop", 32'(bus.InReady), 32'd0);
        cyc();
        chk("t2_ready_after", 32'(bus.InReady), 32'd1);
        chk("t2_count_after", 32'(bus.Count), 32'd3);
        exp_push(5'd9, 32'h999);
        cyc();
        chk("t2_push_pop_count", 32'(bus.Count), 32'd3);
        bus.InValid = 1'b0;
        repeat (5) cyc();
        bus.WbGrant = 1'b0;
        #1;
        chk("t2_drained", 32'(bus.Count), 32'd0);

        // $zero write is consumed and dropped.
        bus.InValid = 1'b1; bus.InReg = 5'd0; bus.InData = 32'hFFFF; bus.WbGrant = 1'b1;
        #1;
        chk("t3_ready", 32'(bus.InReady), 32'd1);
        cyc();
        bus.InValid = 1'b0;
        #1;
        chk("t3_count", 32'(bus.Count), 32'd0);
        chk("t3_no_write", 32'(bus.RegWrite), 32'd0);
        cyc();
        bus.WbGrant = 1'b0;

        // Same register queued twice: forwarding returns the youngest, drain preserves order.
        bus.InValid = 1'b1; bus.InReg = 5'd7; bus.InData = 32'hA;
        exp_push(5'd7, 32'hA);
        cyc();
        bus.InData = 32'hB;
        exp_push(5'd7, 32'hB);
        cyc();
        bus.InValid = 1'b0; bus.LookupReg1 = 5'd7; bus.LookupReg2 = 5'd3;
        #1;
        chk("t4_hit1", 32'(bus.Hit1), FWD ? 32'd1 : 32'd0);
        chk("t4_hitdata1", bus.HitData1, FWD ? 32'hB : 32'd0);
        chk("t4_hit2_miss", 32'(bus.Hit2), 32'd0);
        bus.LookupReg2 = 5'd7;
        #1;
        chk("t4_hit2", 32'(bus.Hit2), FWD ? 32'd1 : 32'd0);
        chk("t4_hitdata2", bus.HitData2, FWD ? 32'hB : 32'd0);
        bus.WbGrant = 1'b1;
        cyc();
        chk("t4_hit1_one_left", 32'(bus.Hit1), FWD ? 32'd1 : 32'd0);
        chk("t4_hitdata1_one_left", bus.HitData1, FWD ? 32'hB : 32'd0);
        cyc();
        bus.WbGrant = 1'b0;
        #1;
        chk("t4_hit1_after", 32'(bus.Hit1), 32'd0);
        chk("t4_count_after", 32'(bus.Count), 32'd0);
        bus.LookupReg1 = 5'd0; bus.LookupReg2 = 5'd0;

        // Reset mid-queue discards everything.
        for (int i = 0; i < 3; i++) begin
            bus.InValid = 1'b1; bus.InReg = 5'(20 + i); bus.InData = 32'hE00 + 32'(i);
            cyc();
        end
        bus.InValid = 1'b0;
        #1;
        chk("t5_count_before", 32'(bus.Count), 32'd3);
        rst = 1'b1; bus.WbGrant = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("t5_count", 32'(bus.Count), 32'd0);
        chk("t5_regwrite", 32'(bus.RegWrite), 32'd0);
        repeat (3) cyc();

        // Streaming: push and pop every cycle.
        for (int i = 0; i < 20; i++) begin
            bus.InValid = 1'b1; bus.InReg = 5'((i % 31) + 1); bus.InData = 32'hC000 + 32'(i);
            exp_push(5'((i % 31) + 1), 32'hC000 + 32'(i));
            cyc();
            chk("t6_count", 32'(bus.Count), 32'd1);
        end
        bus.InValid = 1'b0;
        cyc();
        bus.WbGrant = 1'b0;
        #1;
        chk("t6_drained", 32'(bus.Count), 32'd0);
        chk("pending_writes", 32'(expq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
